ex_stage: RTL and testbench

//  Execute stage: consumes the ID/EX register contents and computes the ALU/shift result.

---
 rtl/ex_stage.sv | 200 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: forwarding, shifter, ALU, NZCV flags, branch resolution and the EX/MEM register.
// Single-cycle ops reach EX/MEM one edge later; DIV/MOD use a restoring divider that stalls the front end.
module ex_stage #(
  parameter int DATA_W     = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc_plus_4_in,
  input  logic [DATA_W-1:0] rd_data1_in,
  input  logic [DATA_W-1:0] rd_data2_in,
  input  logic [DATA_W-1:0] imm_ext_in,
  input  logic [3:0]        rd_in,
  input  logic [1:0]        shift_type_in,
  input  logic [4:0]        shift_amt_in,
  input  logic              reg_write_en_in,
  input  logic              mem_read_en_in,
  input  logic              mem_write_en_in,
  input  logic              mem_to_reg_in,
  input  logic              alu_src_in,
  input  logic              alu_invert_rm_in,
  input  logic [3:0]        alu_op_in,
  input  logic              branch_in,
  input  logic [2:0]        branch_cond_in,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [DATA_W-1:0] fwd_exmem_data,
  input  logic [DATA_W-1:0] fwd_wb_data,
  output logic              stall_out,
  output logic              branch_taken_out,
  output logic [DATA_W-1:0] branch_target_out,
  output logic [DATA_W-1:0] exmem_alu_result,
  output logic [DATA_W-1:0] exmem_store_data,
  output logic [3:0]        exmem_rd,
  output logic              exmem_reg_write_en,
  output logic              exmem_mem_read_en,
  output logic              exmem_mem_write_en,
  output logic              exmem_mem_to_reg,
  output logic [3:0]        flags_out
);
  localparam int CNT_W = $clog2(DIV_CYCLES);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_st_t;

  div_st_t           st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dq_q, dq_d, dr_q, dr_d, dd_q, dd_d;
  logic              mod_q, mod_d;
  logic [3:0]        hrd_q, hrd_d, hctl_q, hctl_d;
  logic [DATA_W-1:0] res_q, res_d, sdat_q, sdat_d;
  logic [3:0]        rd_q, rd_d, ctl_q, ctl_d, flags_q, flags_d;

  logic [DATA_W-1:0]   op_a, rm_fwd, rm_sh, op_b, alu_res;
  logic [2*DATA_W-1:0] ror_w;
  logic [DATA_W:0]     add_w, sub_w, div_sh, div_trial;
  logic                c_flag, v_flag, div_start, nop_in, flag_upd, cond_ok;

  always_comb begin
    case (fwd_a_sel)
      2'b01:   op_a = fwd_exmem_data;
      2'b10:   op_a = fwd_wb_data;
      default: op_a = rd_data1_in;
    endcase
    case (fwd_b_sel)
      2'b01:   rm_fwd = fwd_exmem_data;
      2'b10:   rm_fwd = fwd_wb_data;
      default: rm_fwd = rd_data2_in;
    endcase
  end

  assign ror_w = {rm_fwd, rm_fwd} >> shift_amt_in;

  always_comb begin
    case (shift_type_in)
      2'b00:   rm_sh = rm_fwd << shift_amt_in;
      2'b01:   rm_sh = rm_fwd >> shift_amt_in;
      2'b10:   rm_sh = $signed(rm_fwd) >>> shift_amt_in;
      default: rm_sh = ror_w[DATA_W-1:0];
    endcase
    op_b = alu_src_in ? imm_ext_in : rm_sh;
    if (alu_invert_rm_in) op_b = ~op_b;
  end

  // Carry follows the ARM convention: C = 1 means no borrow on subtract.
  assign add_w = {1'b0, op_a} + {1'b0, op_b};
  assign sub_w = {1'b0, op_a} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    alu_res = add_w[DATA_W-1:0];
    c_flag  = add_w[DATA_W];
    v_flag  = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (add_w[DATA_W-1] != op_a[DATA_W-1]);
    case (alu_op_in)
      4'b0001, 4'b1110: begin
        alu_res = sub_w[DATA_W-1:0];
        c_flag  = sub_w[DATA_W];
        v_flag  = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (sub_w[DATA_W-1] != op_a[DATA_W-1]);
      end
      4'b0010:                   begin alu_res = op_a * op_b;  c_flag = 1'b0; v_flag = 1'b0; end
      4'b0011, 4'b0100:          begin alu_res = '0;           c_flag = 1'b0; v_flag = 1'b0; end
      4'b0101, 4'b1000, 4'b1111: begin alu_res = op_a & op_b;  c_flag = 1'b0; v_flag = 1'b0; end
      4'b0110:                   begin alu_res = op_a | op_b;  c_flag = 1'b0; v_flag = 1'b0; end
      4'b0111:                   begin alu_res = op_a ^ op_b;  c_flag = 1'b0; v_flag = 1'b0; end
      4'b1001:                   begin alu_res = ~op_b;        c_flag = 1'b0; v_flag = 1'b0; end
      4'b1100:                   begin alu_res = op_b;         c_flag = 1'b0; v_flag = 1'b0; end
      default: ;
    endcase
  end

  assign div_start = reg_write_en_in && ((alu_op_in == 4'b0011) || (alu_op_in == 4'b0100));
  // An all-zero bubble must not disturb the flags, so it is excluded from compare updates.
  assign nop_in    = (alu_op_in == 4'b0000) && !alu_src_in && !alu_invert_rm_in && !mem_to_reg_in;
  assign flag_upd  = !branch_in && !reg_write_en_in && !mem_read_en_in && !mem_write_en_in && !nop_in;

  always_comb begin
    case (branch_cond_in)
      3'b000:  cond_ok = 1'b1;
      3'b001:  cond_ok = flags_q[2];
      3'b010:  cond_ok = !flags_q[2];
      3'b011:  cond_ok = flags_q[3] != flags_q[0];
      3'b100:  cond_ok = !flags_q[2] && (flags_q[3] == flags_q[0]);
      default: cond_ok = 1'b0;
    endcase
  end

  assign stall_out         = !reset && (((st_q == IDLE) && div_start) || (st_q == BUSY));
  assign branch_taken_out  = branch_in && cond_ok && !stall_out;
  assign branch_target_out = pc_plus_4_in + {imm_ext_in[DATA_W-3:0], 2'b00};

  assign div_sh    = {dr_q, dq_q[DATA_W-1]};
  assign div_trial = div_sh - {1'b0, dd_q};

  always_comb begin
    st_d = st_q;  cnt_d = cnt_q;  dq_d = dq_q;  dr_d = dr_q;  dd_d = dd_q;
    mod_d = mod_q;  hrd_d = hrd_q;  hctl_d = hctl_q;  flags_d = flags_q;
    res_d = '0;  sdat_d = '0;  rd_d = '0;  ctl_d = '0;
    case (st_q)
      IDLE: begin
        if (div_start) begin
          mod_d  = alu_op_in[2];
          hrd_d  = rd_in;
          hctl_d = {reg_write_en_in, mem_read_en_in, mem_write_en_in, mem_to_reg_in};
          if (op_b == '0) begin
            dq_d = '1;
            dr_d = op_a;
            st_d = DONE;
          end else begin
            dq_d  = op_a;
            dr_d  = '0;
            dd_d  = op_b;
            cnt_d = CNT_W'(DIV_CYCLES - 1);
            st_d  = BUSY;
          end
        end else if (!branch_in) begin
          res_d  = alu_res;
          sdat_d = rm_fwd;
          rd_d   = rd_in;
          ctl_d  = {reg_write_en_in, mem_read_en_in, mem_write_en_in, mem_to_reg_in};
          if (flag_upd) flags_d = {alu_res[DATA_W-1], alu_res == '0, c_flag, v_flag};
        end
      end
      BUSY: begin
        if (!div_trial[DATA_W]) begin
          dr_d = div_trial[DATA_W-1:0];
          dq_d = {dq_q[DATA_W-2:0], 1'b1};
        end else begin
          dr_d = div_sh[DATA_W-1:0];
          dq_d = {dq_q[DATA_W-2:0], 1'b0};
        end
        if (cnt_q == '0) st_d = DONE;
        else             cnt_d = cnt_q - 1'b1;
      end
      default: begin
        res_d = mod_q ? dr_q : dq_q;
        rd_d  = hrd_q;
        ctl_d = hctl_q;
        st_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= IDLE;  cnt_q <= '0;  dq_q <= '0;  dr_q <= '0;  dd_q <= '0;
      mod_q <= 1'b0;  hrd_q <= '0;  hctl_q <= '0;
      res_q <= '0;  sdat_q <= '0;  rd_q <= '0;  ctl_q <= '0;  flags_q <= '0;
    end else begin
      st_q <= st_d;  cnt_q <= cnt_d;  dq_q <= dq_d;  dr_q <= dr_d;  dd_q <= dd_d;
      mod_q <= mod_d;  hrd_q <= hrd_d;  hctl_q <= hctl_d;
      res_q <= res_d;  sdat_q <= sdat_d;  rd_q <= rd_d;  ctl_q <= ctl_d;  flags_q <= flags_d;
    end
  end

  assign exmem_alu_result   = res_q;
  assign exmem_store_data   = sdat_q;
  assign exmem_rd           = rd_q;
  assign exmem_reg_write_en = ctl_q[3];
  assign exmem_mem_read_en  = ctl_q[2];
  assign exmem_mem_write_en = ctl_q[1];
  assign exmem_mem_to_reg   = ctl_q[0];
  assign flags_out          = flags_q;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table, directed flag/branch/divider sequences, randomized ops vs. a reference model.
module tb_ex_stage;
  logic        clk = 1'b0, reset;
  logic [31:0] pc_plus_4_in, rd_data1_in, rd_data2_in, imm_ext_in, fwd_exmem_data, fwd_wb_data;
  logic [3:0]  rd_in, alu_op_in;
  logic [1:0]  shift_type_in, fwd_a_sel, fwd_b_sel;
  logic [4:0]  shift_amt_in;
  logic        reg_write_en_in, mem_read_en_in, mem_write_en_in, mem_to_reg_in, alu_src_in, alu_invert_rm_in, branch_in;
  logic [2:0]  branch_cond_in;
  logic        stall_out, branch_taken_out;
  logic [31:0] branch_target_out, exmem_alu_result, exmem_store_data;
  logic [3:0]  exmem_rd, flags_out;
  logic        exmem_reg_write_en, exmem_mem_read_en, exmem_mem_write_en, exmem_mem_to_reg;

  int checks = 0, failures = 0;

  ex_stage dut (
    .clk(clk), .reset(reset), .pc_plus_4_in(pc_plus_4_in), .rd_data1_in(rd_data1_in),
    .rd_data2_in(rd_data2_in), .imm_ext_in(imm_ext_in), .rd_in(rd_in), .shift_type_in(shift_type_in),
    .shift_amt_in(shift_amt_in), .reg_write_en_in(reg_write_en_in), .mem_read_en_in(mem_read_en_in),
    .mem_write_en_in(mem_write_en_in), .mem_to_reg_in(mem_to_reg_in), .alu_src_in(alu_src_in),
    .alu_invert_rm_in(alu_invert_rm_in), .alu_op_in(alu_op_in), .branch_in(branch_in),
    .branch_cond_in(branch_cond_in), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .fwd_exmem_data(fwd_exmem_data), .fwd_wb_data(fwd_wb_data), .stall_out(stall_out),
    .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out),
    .exmem_alu_result(exmem_alu_result), .exmem_store_data(exmem_store_data), .exmem_rd(exmem_rd),
    .exmem_reg_write_en(exmem_reg_write_en), .exmem_mem_read_en(exmem_mem_read_en),
    .exmem_mem_write_en(exmem_mem_write_en), .exmem_mem_to_reg(exmem_mem_to_reg), .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    pc_plus_4_in = '0; rd_data1_in = '0; rd_data2_in = '0; imm_ext_in = '0; rd_in = '0;
    shift_type_in = '0; shift_amt_in = '0; reg_write_en_in = 0; mem_read_en_in = 0; mem_write_en_in = 0;
    mem_to_reg_in = 0; alu_src_in = 0; alu_invert_rm_in = 0; alu_op_in = '0; branch_in = 0;
    branch_cond_in = '0; fwd_a_sel = '0; fwd_b_sel = '0; fwd_exmem_data = '0; fwd_wb_data = '0;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a, rm, imm, input logic src,
                        input logic [1:0] st, input logic [4:0] amt, input logic inv, input logic [3:0] rd, input logic rw);
    idle();
    alu_op_in = op; rd_data1_in = a; rd_data2_in = rm; imm_ext_in = imm; alu_src_in = src;
    shift_type_in = st; shift_amt_in = amt; alu_invert_rm_in = inv; rd_in = rd; reg_write_en_in = rw;
  endtask

  // Reference model: plain arithmetic over the operation definitions.
  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [1:0] t, input logic [4:0] n);
    logic [31:0] r = x;
    case (t)
      2'd0: r = x << n;
      2'd1: r = x >> n;
      2'd2: r = $signed(x) >>> n;
      default: for (int i = 0; i < int'(n); i++) r = {r[0], r[31:1]};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
    longint unsigned p;
    case (op)
      4'd1, 4'd14:        return a - b;
      4'd2:               begin p = longint'(a) * longint'(b); return p[31:0]; end
      4'd5, 4'd8, 4'd15:  return a & b;
      4'd6:               return a | b;
      4'd7:               return a ^ b;
      4'd9:               return ~b;
      4'd12:              return b;
      default:            return a + b;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags(input logic [3:0] op, input logic [31:0] a, b, res);
    logic   c = 1'b0, v = 1'b0;
    longint d;
    if (op == 4'd1 || op == 4'd14) begin
      c = (a >= b);
      d = longint'($signed(a)) - longint'($signed(b));
      v = (d != longint'($signed(res)));
    end
    return {res[31], res == 32'd0, c, v};
  endfunction

  task automatic run_div(input string nm, input logic [31:0] a, b, input logic m, input logic [31:0] exp, input int exp_stall);
    int cnt = 0;
    set_op(m ? 4'd4 : 4'd3, a, b, 32'd0, 1'b0, 2'd0, 5'd0, 1'b0, 4'h9, 1'b1);
    #1;
    while (stall_out === 1'b1 && cnt < 200) begin
      cnt++;
      @(posedge clk); #1;
      if (cnt == 1) chk({nm, "_bubble"}, {31'd0, exmem_reg_write_en}, 32'd0);
    end
    chk({nm, "_stall_cycles"}, cnt, exp_stall);
    @(posedge clk); #1;
    idle();
    chk({nm, "_result"}, exmem_alu_result, exp);
    chk({nm, "_rd_rw"}, {27'd0, exmem_rd, exmem_reg_write_en}, {27'd0, 4'h9, 1'b1});
  endtask

  typedef struct {
    logic [3:0] op; logic [31:0] a, rm, imm; logic src; logic [1:0] st; logic [4:0] amt; logic inv; logic [31:0] exp;
  } vec_t;
  vec_t vt[20];

  logic [3:0] ops_rw[14] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
  logic [3:0] ops_cmp[9] = '{4'd1, 4'd14, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd15};

  initial begin
    logic [31:0] a, rm, b, exp_res;
    logic [3:0]  exp_flags;
    logic [3:0]  op;
    logic        rw, mr, mw, m2r;
    logic [2:0]  br_exp;

    vt[0]  = '{4'd0,  32'd5,        32'd0,        32'd7, 1'b1, 2'd0, 5'd0,  1'b0, 32'd12};
    vt[1]  = '{4'd1,  32'd10,       32'd4,        32'd0, 1'b0, 2'd0, 5'd0,  1'b0, 32'd6};
    vt[2]  = '{4'd2,  32'd6,        32'd7,        32'd0, 1'b0, 2'd0, 5'd0,  1'b0, 32'd42};
    vt[3]  = '{4'd5,  32'hF0F0,     32'hFF00,     32'd0, 1'b0, 2'd0, 5'd0,  1'b0, 32'hF000};
    vt[4]  = '{4'd6,  32'hF0,       32'h0F,       32'd0, 1'b0, 2'd0, 5'd0,  1'b0, 32'hFF};
    vt[5]  = '{4'd7,  32'hFF,       32'h0F,       32'd0, 1'b0, 2'd0, 5'd0,  1'b0, 32'hF0};
    vt[6]  = '{4'd8,  32'hFF,       32'h0F,       32'd0, 1'b0, 2'd0, 5'd0,  1'b1, 32'hF0};
    vt[7]  = '{4'd9,  32'd0,        32'd0,        32'd0, 1'b0, 2'd0, 5'd0,  1'b0, 32'hFFFFFFFF};
    vt[8]  = '{4'd12, 32'd0,        32'h1234,     32'd0, 1'b0, 2'd0, 5'd0,  1'b0, 32'h1234};
    vt[9]  = '{4'd12, 32'd0,        32'h1,        32'd0, 1'b0, 2'd3, 5'd1,  1'b0, 32'h80000000};
    vt[10] = '{4'd12, 32'd0,        32'h80000000, 32'd0, 1'b0, 2'd2, 5'd4,  1'b0, 32'hF8000000};
    vt[11] = '{4'd12, 32'd0,        32'h80000000, 32'd0, 1'b0, 2'd1, 5'd4,  1'b0, 32'h08000000};
    vt[12] = '{4'd12, 32'd0,        32'h1234,     32'd0, 1'b0, 2'd3, 5'd0,  1'b0, 32'h1234};
    vt[13] = '{4'd10, 32'd2,        32'd3,        32'd0, 1'b0, 2'd0, 5'd0,  1'b0, 32'd5};
    vt[14] = '{4'd14, 32'd10,       32'd4,        32'd0, 1'b0, 2'd0, 5'd0,  1'b0, 32'd6};
    vt[15] = '{4'd13, 32'd2,        32'd3,        32'd0, 1'b0, 2'd0, 5'd0,  1'b0, 32'd5};
    vt[16] = '{4'd2,  32'h10000,    32'h10000,    32'd0, 1'b0, 2'd0, 5'd0,  1'b0, 32'd0};
    vt[17] = '{4'd0,  32'hFFFFFFFF, 32'd1,        32'd0, 1'b0, 2'd0, 5'd0,  1'b0, 32'd0};
    vt[18] = '{4'd15, 32'hF0F0,     32'h0FF0,     32'd0, 1'b0, 2'd0, 5'd0,  1'b0, 32'hF0};
    vt[19] = '{4'd12, 32'd0,        32'd3,        32'd0, 1'b0, 2'd0, 5'd31, 1'b0, 32'h80000000};

    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", exmem_alu_result, 32'd0);
    chk("reset_ctl", {23'd0, exmem_rd, exmem_reg_write_en, exmem_mem_read_en, exmem_mem_write_en, exmem_mem_to_reg},
        32'd0);
    chk("reset_flags_stall", {27'd0, flags_out, stall_out}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      set_op(vt[i].op, vt[i].a, vt[i].rm, vt[i].imm, vt[i].src, vt[i].st, vt[i].amt, vt[i].inv, 4'(i), 1'b1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_result", i), exmem_alu_result, vt[i].exp);
      chk($sformatf("vec%0d_rd_rw", i), {27'd0, exmem_rd, exmem_reg_write_en}, {27'd0, 4'(i), 1'b1});
    end

    // Forwarded A from EX/MEM, forwarded Rm from WB shifted left by 4.
    set_op(4'd0, 32'hDEAD, 32'hBAD, 32'd0, 1'b0, 2'd0, 5'd4, 1'b0, 4'h3, 1'b1);
    fwd_a_sel = 2'b01; fwd_exmem_data = 32'h10; fwd_b_sel = 2'b10; fwd_wb_data = 32'h1;
    @(posedge clk); #1;
    chk("fwd_result", exmem_alu_result, 32'h20);
    chk("fwd_store_data", exmem_store_data, 32'h1);

    // Compares and branch resolution on the registered flags.
    set_op(4'd1, 32'd3, 32'd5, 32'd0, 1'b0, 2'd0, 5'd0, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
    chk("cmp_3_5_flags", {28'd0, flags_out}, 32'h8);
    for (int c = 0; c < 8; c++) begin
      idle();
      branch_in = 1'b1; branch_cond_in = 3'(c); pc_plus_4_in = 32'h100; imm_ext_in = 32'hFFFFFFFE;
      reg_write_en_in = 1'b1; rd_in = 4'h7;
      #1;
      br_exp = (c == 0 || c == 2 || c == 3) ? 3'd1 : 3'd0;
      chk($sformatf("branch_cond%0d_taken", c), {31'd0, branch_taken_out}, {29'd0, br_exp});
      chk($sformatf("branch_cond%0d_target", c), branch_target_out, 32'hF8);
    end
    @(posedge clk); #1;
    chk("branch_bubble", {27'd0, exmem_rd, exmem_reg_write_en}, 32'd0);
    chk("branch_keeps_flags", {28'd0, flags_out}, 32'h8);

    set_op(4'd14, 32'd7, 32'd7, 32'd0, 1'b0, 2'd0, 5'd0, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
    chk("cmp_eq_flags", {28'd0, flags_out}, 32'h6);
    idle(); branch_in = 1'b1; branch_cond_in = 3'b001;
    #1 chk("beq_taken", {31'd0, branch_taken_out}, 32'd1);
    branch_cond_in = 3'b100;
    #1 chk("bgt_not_taken", {31'd0, branch_taken_out}, 32'd0);

    set_op(4'd1, 32'h80000000, 32'd1, 32'd0, 1'b0, 2'd0, 5'd0, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
    chk("cmp_ovf_flags", {28'd0, flags_out}, 32'h3);
    set_op(4'd5, 32'h80000000, 32'h80000001, 32'd0, 1'b0, 2'd0, 5'd0, 1'b0, 4'h0, 1'b0);
    @(posedge clk); #1;
    chk("tst_flags", {28'd0, flags_out}, 32'h8);

    run_div("div_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 33);
    run_div("mod_100_7", 32'd100, 32'd7, 1'b1, 32'd2, 33);
    run_div("div_by_0", 32'd55, 32'd0, 1'b0, 32'hFFFFFFFF, 1);
    run_div("mod_9_0", 32'd9, 32'd0, 1'b1, 32'd9, 1);

    // Reset while the divider is busy discards the division.
    set_op(4'd3, 32'd1000, 32'd3, 32'd0, 1'b0, 2'd0, 5'd0, 1'b0, 4'h9, 1'b1);
    repeat (5) @(posedge clk);
    #1 chk("busy_stall", {31'd0, stall_out}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_busy_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_busy_exmem", {23'd0, exmem_rd, exmem_reg_write_en, exmem_mem_read_en, exmem_mem_write_en, exmem_mem_to_reg},
        32'd0);
    chk("rst_busy_flags", {28'd0, flags_out}, 32'd0);
    idle();
    @(posedge clk); #1;
    reset = 1'b0;
    run_div("div_after_rst", 32'd1000, 32'd3, 1'b0, 32'd333, 33);

    exp_flags = 4'h0;
    for (int n = 0; n < 300; n++) begin
      rw  = 1'($urandom_range(0, 1));
      op  = rw ? ops_rw[$urandom_range(0, 13)] : ops_cmp[$urandom_range(0, 8)];
      mr  = ($urandom_range(0, 3) == 0);
      mw  = ($urandom_range(0, 3) == 0);
      m2r = 1'($urandom_range(0, 1));
      set_op(op, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rw);
      mem_read_en_in = mr; mem_write_en_in = mw; mem_to_reg_in = m2r;
      fwd_a_sel = 2'($urandom_range(0, 3)); fwd_b_sel = 2'($urandom_range(0, 3));
      fwd_exmem_data = $urandom; fwd_wb_data = $urandom;
      a  = (fwd_a_sel == 2'b01) ? fwd_exmem_data : (fwd_a_sel == 2'b10) ? fwd_wb_data : rd_data1_in;
      rm = (fwd_b_sel == 2'b01) ? fwd_exmem_data : (fwd_b_sel == 2'b10) ? fwd_wb_data : rd_data2_in;
      b  = alu_src_in ? imm_ext_in : ref_shift(rm, shift_type_in, shift_amt_in);
      if (alu_invert_rm_in) b = ~b;
      exp_res = ref_alu(op, a, b);
      if (!rw && !mr && !mw) exp_flags = ref_flags(op, a, b, exp_res);
      @(posedge clk); #1;
      chk($sformatf("rnd%0d_op%0d_result", n, op), exmem_alu_result, exp_res);
      chk($sformatf("rnd%0d_store", n), exmem_store_data, rm);
      chk($sformatf("rnd%0d_ctl", n),
          {23'd0, exmem_rd, exmem_reg_write_en, exmem_mem_read_en, exmem_mem_write_en, exmem_mem_to_reg},
          {23'd0, rd_in, rw, mr, mw, m2r});
      chk($sformatf("rnd%0d_flags", n), {28'd0, flags_out}, {28'd0, exp_flags});
    end

    for (int n = 0; n < 8; n++) begin
      a  = $urandom;
      b  = (n % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      rw = 1'($urandom_range(0, 1));
      run_div($sformatf("rnd_div%0d", n), a, b, rw, rw ? (a % b) : (a / b), 33);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
